// File: rtl/dram_ctrl_pkg.sv
// Shared types and constants for the DRAM command sequencer: FSM states,
// pin-level command encodings, address field widths and delay counter width.
package dram_ctrl_pkg;

  localparam int ROW_W      = 11;
  localparam int COL_W      = 10;
  localparam int ADDR_W     = ROW_W + COL_W;
  localparam int TMO_MARGIN = 4;
  // Wide enough for TCL+TMO_MARGIN-1 with every timing parameter <= 8
  localparam int CNT_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_PRE_WAIT, ST_ACT, ST_ACT_WAIT, ST_ACCESS, ST_RD_WAIT, ST_WR_WAIT
  } dram_state_e;

  typedef struct packed {
    logic             csn;
    logic             rasn;
    logic             casn;
    logic [3:0]       wen;
    logic [ROW_W-1:0] a;
  } dram_cmd_t;

  localparam dram_cmd_t CMD_IDLE = '{csn: 1'b1, rasn: 1'b1, casn: 1'b1, wen: 4'hF, a: '0};

  function automatic dram_cmd_t cmd_act(input logic [ROW_W-1:0] row);
    dram_cmd_t c = CMD_IDLE;
    c.csn = 1'b0; c.rasn = 1'b0; c.a = row;
    return c;
  endfunction

  function automatic dram_cmd_t cmd_pre(input logic [ROW_W-1:0] row);
    dram_cmd_t c = CMD_IDLE;
    c.csn = 1'b0; c.rasn = 1'b0; c.wen = 4'h0; c.a = row;
    return c;
  endfunction

  function automatic dram_cmd_t cmd_rw(input logic wr, input logic [COL_W-1:0] col,
                                       input logic [3:0] wstrb);
    dram_cmd_t c = CMD_IDLE;
    c.csn = 1'b0; c.casn = 1'b0; c.a = {1'b0, col};
    if (wr) c.wen = ~wstrb;
    return c;
  endfunction

endpackage

// File: rtl/dram_ctrl_if.sv
// Word request / one-shot response channel between the AXI-side wrapper and dram_ctrl.
interface dram_ctrl_if;
  logic                              req_valid;
  logic                              req_ready;
  logic                              req_write;
  logic [dram_ctrl_pkg::ADDR_W-1:0]  req_addr;
  logic [3:0]                        req_wstrb;
  logic [31:0]                       req_wdata;
  logic                              resp_valid;
  logic [31:0]                       resp_rdata;
  logic                              resp_err;

  modport master (output req_valid, req_write, req_addr, req_wstrb, req_wdata,
                  input  req_ready, resp_valid, resp_rdata, resp_err);
  modport slave  (input  req_valid, req_write, req_addr, req_wstrb, req_wdata,
                  output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

// File: rtl/dram_delay_cnt.sv
// Loadable down-counter shared by all WAIT states; done marks the last wait cycle.
module dram_delay_cnt
  import dram_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         dram_clk,
  input  logic         dram_rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;

  always_ff @(posedge dram_clk or negedge dram_rstn) begin
    if (!dram_rstn)      cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - W'(1);
  end

  assign done = (cnt == W'(1));
endmodule

// File: rtl/dram_ctrl.sv
// Single-port DRAM command sequencer (ACT/RD/WR/PRE with parameterised gaps).
// DRAM_OPEN_PAGE_EN keeps rows open across requests; otherwise every access closes its row.
module dram_ctrl
  import dram_ctrl_pkg::*;
#(
  parameter int unsigned TRCD = 5,
  parameter int unsigned TCL  = 5,
  parameter int unsigned TRP  = 5,
  parameter int unsigned TWR  = 5
) (
  input  logic              dram_clk,
  input  logic              dram_rstn,
  dram_ctrl_if.slave        bus,
  output logic              DRAM_CSn,
  output logic              DRAM_RASn,
  output logic              DRAM_CASn,
  output logic [3:0]        DRAM_WEn,
  output logic [ROW_W-1:0]  DRAM_A,
  output logic [31:0]       DRAM_D,
  input  logic [31:0]       DRAM_Q,
  input  logic              DRAM_valid
);
  dram_state_e      state;
  dram_cmd_t        cmd;
  logic [31:0]      dq_d;
  logic             req_ready_q, resp_valid_q, resp_err_q;
  logic [31:0]      resp_rdata_q;
  logic             row_open;
  logic [ROW_W-1:0] open_row;
  logic             l_write;
  logic [COL_W-1:0] l_col;
  logic [3:0]       l_wstrb;
  logic [31:0]      l_wdata;
`ifdef DRAM_OPEN_PAGE_EN
  logic [ROW_W-1:0] l_row;
`else
  logic [31:0]      pend_rdata;
  logic             pend_err;
`endif

  logic             cnt_load, cnt_done;
  logic [CNT_W-1:0] cnt_val;

  logic [ROW_W-1:0] req_row;
  logic             accept, hit, go_access, pre_done, acc_done, done_err;
  logic             acc_write;
  logic [COL_W-1:0] acc_col;
  logic [3:0]       acc_wstrb;
  logic [31:0]      acc_wdata, done_rdata;

  assign req_row   = bus.req_addr[ADDR_W-1:COL_W];
  assign accept    = (state == ST_IDLE) && req_ready_q && bus.req_valid;
  assign hit       = row_open && (open_row == req_row);

  // A row hit goes straight to the column command, so it reads the request bus directly
  assign go_access = (accept && hit) || (state == ST_ACT && TRCD == 1) ||
                     (state == ST_ACT_WAIT && cnt_done);
  assign acc_write = accept ? bus.req_write               : l_write;
  assign acc_col   = accept ? bus.req_addr[COL_W-1:0]     : l_col;
  assign acc_wstrb = accept ? bus.req_wstrb               : l_wstrb;
  assign acc_wdata = accept ? bus.req_wdata               : l_wdata;

  assign pre_done  = (state == ST_PRE && TRP == 1) || (state == ST_PRE_WAIT && cnt_done);
  assign acc_done  = (state == ST_ACCESS && l_write && TWR == 1) ||
                     (state == ST_WR_WAIT && cnt_done) ||
                     (state == ST_RD_WAIT && (DRAM_valid || cnt_done));
  assign done_err   = (state == ST_RD_WAIT) && !DRAM_valid;
  assign done_rdata = (state == ST_RD_WAIT && DRAM_valid) ? DRAM_Q : '0;

  always_comb begin
    cnt_load = 1'b1;
    cnt_val  = '0;
    unique case (state)
      ST_PRE:    cnt_val = CNT_W'(TRP - 1);
      ST_ACT:    cnt_val = CNT_W'(TRCD - 1);
      ST_ACCESS: cnt_val = l_write ? CNT_W'(TWR - 1) : CNT_W'(TCL + TMO_MARGIN - 1);
      default:   cnt_load = 1'b0;
    endcase
  end

  dram_delay_cnt #(.W(CNT_W)) u_dly (
    .dram_clk (dram_clk),
    .dram_rstn(dram_rstn),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  always_ff @(posedge dram_clk or negedge dram_rstn) begin
    if (!dram_rstn) begin
      state        <= ST_IDLE;
      cmd          <= CMD_IDLE;
      dq_d         <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      row_open     <= 1'b0;
      open_row     <= '0;
      l_write      <= 1'b0;
      l_col        <= '0;
      l_wstrb      <= '0;
      l_wdata      <= '0;
`ifdef DRAM_OPEN_PAGE_EN
      l_row        <= '0;
`else
      pend_rdata   <= '0;
      pend_err     <= 1'b0;
`endif
    end else begin
      cmd          <= CMD_IDLE;
      dq_d         <= '0;
      resp_valid_q <= 1'b0;
      req_ready_q  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          // Stays low through the response cycle, so accept and resp never coincide
          req_ready_q <= !accept;
          if (accept) begin
            l_write <= bus.req_write;
            l_col   <= bus.req_addr[COL_W-1:0];
            l_wstrb <= bus.req_wstrb;
            l_wdata <= bus.req_wdata;
`ifdef DRAM_OPEN_PAGE_EN
            l_row   <= req_row;
`endif
            if (row_open && !hit) begin
              state    <= ST_PRE;
              cmd      <= cmd_pre(open_row);
              row_open <= 1'b0;
            end else if (!row_open) begin
              state    <= ST_ACT;
              cmd      <= cmd_act(req_row);
              row_open <= 1'b1;
              open_row <= req_row;
            end
          end
        end
        ST_PRE:    if (TRP > 1)  state <= ST_PRE_WAIT;
        ST_ACT:    if (TRCD > 1) state <= ST_ACT_WAIT;
        ST_ACCESS: begin
          if (!l_write)     state <= ST_RD_WAIT;
          else if (TWR > 1) state <= ST_WR_WAIT;
        end
        default: ;
      endcase

      if (go_access) begin
        state <= ST_ACCESS;
        cmd   <= cmd_rw(acc_write, acc_col, acc_wstrb);
        if (acc_write) dq_d <= acc_wdata;
      end

      if (pre_done) begin
`ifdef DRAM_OPEN_PAGE_EN
        state    <= ST_ACT;
        cmd      <= cmd_act(l_row);
        row_open <= 1'b1;
        open_row <= l_row;
`else
        state        <= ST_IDLE;
        resp_valid_q <= 1'b1;
        resp_rdata_q <= pend_rdata;
        resp_err_q   <= pend_err;
`endif
      end

      if (acc_done) begin
`ifdef DRAM_OPEN_PAGE_EN
        state        <= ST_IDLE;
        resp_valid_q <= 1'b1;
        resp_rdata_q <= done_rdata;
        resp_err_q   <= done_err;
`else
        // Result is parked until the row is closed and TRP has elapsed
        state      <= ST_PRE;
        cmd        <= cmd_pre(open_row);
        row_open   <= 1'b0;
        pend_rdata <= done_rdata;
        pend_err   <= done_err;
`endif
      end
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  assign DRAM_CSn  = cmd.csn;
  assign DRAM_RASn = cmd.rasn;
  assign DRAM_CASn = cmd.casn;
  assign DRAM_WEn  = cmd.wen;
  assign DRAM_A    = cmd.a;
  assign DRAM_D    = dq_d;
endmodule

// File: tb/tb_dram_ctrl.sv
// Directed bench for dram_ctrl: expected pin commands and responses are queued per request
// and popped by a negedge monitor as the DUT produces them.
module tb_dram_ctrl;
  localparam int TRCD = 3;
  localparam int TCL  = 4;
  localparam int TRP  = 2;
  localparam int TWR  = 4;
`ifdef DRAM_OPEN_PAGE_EN
  localparam bit OPEN_PAGE = 1'b1;
`else
  localparam bit OPEN_PAGE = 1'b0;
`endif

  typedef struct { int cyc; logic [49:0] pins; } exp_cmd_t;
  typedef struct { int cyc; logic [31:0] rdata; logic err; } exp_resp_t;

  logic        dram_clk, dram_rstn;
  logic        DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_valid;
  logic [3:0]  DRAM_WEn;
  logic [10:0] DRAM_A;
  logic [31:0] DRAM_D, DRAM_Q;

  int n_vec = 0, n_err = 0, cyc = 0;
  exp_cmd_t  cmd_q[$];
  exp_resp_t resp_q[$];
  bit          m_open = 1'b0;
  logic [10:0] m_row  = '0;
  exp_cmd_t  mc;
  exp_resp_t mr;

  dram_ctrl_if bus();

  dram_ctrl #(.TRCD(TRCD), .TCL(TCL), .TRP(TRP), .TWR(TWR)) dut (
    .dram_clk  (dram_clk),
    .dram_rstn (dram_rstn),
    .bus       (bus),
    .DRAM_CSn  (DRAM_CSn),
    .DRAM_RASn (DRAM_RASn),
    .DRAM_CASn (DRAM_CASn),
    .DRAM_WEn  (DRAM_WEn),
    .DRAM_A    (DRAM_A),
    .DRAM_D    (DRAM_D),
    .DRAM_Q    (DRAM_Q),
    .DRAM_valid(DRAM_valid)
  );

  initial dram_clk = 1'b0;
  always #5 dram_clk = ~dram_clk;
  always @(posedge dram_clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [49:0] pv(input logic csn, input logic rasn, input logic casn,
                                     input logic [3:0] wen, input logic [10:0] a,
                                     input logic [31:0] d);
    return {csn, rasn, casn, wen, a, d};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge dram_clk);
  endtask

  // Pin and response monitor
  always @(negedge dram_clk) begin
    if (dram_rstn === 1'b1) begin
      if (DRAM_CSn === 1'b0) begin
        check("cmd_expected", 64'(cmd_q.size() != 0), 64'd1);
        if (cmd_q.size() != 0) begin
          mc = cmd_q.pop_front();
          check("cmd_cycle", 64'(cyc), 64'(mc.cyc));
          check("cmd_pins", 64'({DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn, DRAM_A, DRAM_D}),
                64'(mc.pins));
        end
      end else begin
        check("idle_pins", 64'({DRAM_RASn, DRAM_CASn, DRAM_WEn}), 64'h3F);
      end
      if (bus.resp_valid === 1'b1) begin
        check("resp_expected", 64'(resp_q.size() != 0), 64'd1);
        check("ready_low_on_resp", 64'(bus.req_ready), 64'd0);
        if (resp_q.size() != 0) begin
          mr = resp_q.pop_front();
          check("resp_cycle", 64'(cyc), 64'(mr.cyc));
          check("resp_rdata", 64'(bus.resp_rdata), 64'(mr.rdata));
          check("resp_err", 64'(bus.resp_err), 64'(mr.err));
        end
      end
    end
  end

  // qlat: cycles after RD/WR at which DRAM_valid pulses (-1 = never); on writes it is a stray pulse.
  // abort: pull reset in the cycle after the ACT command.
  task automatic do_req(input bit wr, input logic [20:0] addr, input logic [3:0] strb,
                        input logic [31:0] wd, input int qlat, input logic [31:0] q,
                        input bit abort);
    exp_cmd_t ec;
    exp_resp_t er;
    int c0, t, tact, tacc, f, n;
    logic [10:0] row;
    logic [9:0]  col;
    row = addr[20:10];
    col = addr[9:0];
    @(negedge dram_clk);
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 200) begin @(negedge dram_clk); n++; end
    check("req_ready_wait", 64'(bus.req_ready), 64'd1);
    c0 = cyc; t = c0 + 1; tact = c0 + 1;
    if (!(OPEN_PAGE && m_open && m_row == row)) begin
      if (OPEN_PAGE && m_open) begin
        ec.cyc = t; ec.pins = pv(1'b0, 1'b0, 1'b1, 4'h0, m_row, 32'h0); cmd_q.push_back(ec);
        t += TRP;
      end
      ec.cyc = t; ec.pins = pv(1'b0, 1'b0, 1'b1, 4'hF, row, 32'h0); cmd_q.push_back(ec);
      tact = t; t += TRCD;
      m_open = 1'b1; m_row = row;
    end
    tacc = t;
    ec.cyc  = tacc;
    ec.pins = wr ? pv(1'b0, 1'b1, 1'b0, ~strb, {1'b0, col}, wd)
                 : pv(1'b0, 1'b1, 1'b0, 4'hF, {1'b0, col}, 32'h0);
    if (!abort) cmd_q.push_back(ec);
    if (wr)             f = tacc + TWR;
    else if (qlat >= 0) f = tacc + qlat + 1;
    else                f = tacc + TCL + 4;
    er.rdata = (!wr && qlat >= 0) ? q : 32'h0;
    er.err   = !wr && (qlat < 0);
    if (!OPEN_PAGE) begin
      ec.cyc = f; ec.pins = pv(1'b0, 1'b0, 1'b1, 4'h0, row, 32'h0);
      if (!abort) cmd_q.push_back(ec);
      f += TRP;
      m_open = 1'b0;
    end
    er.cyc = f;
    if (!abort) resp_q.push_back(er);

    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr;
    bus.req_wstrb = strb; bus.req_wdata = wd;
    @(posedge dram_clk);
    #1;
    bus.req_valid = 1'b0; bus.req_write = 1'($urandom); bus.req_addr = 21'($urandom);
    bus.req_wstrb = 4'($urandom); bus.req_wdata = $urandom;

    if (abort) begin
      wait_cyc(tact + 1);
      #2 dram_rstn = 1'b0;
      #1;
      check("rst_mid_pins", 64'({DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn, DRAM_A, DRAM_D}),
            64'(pv(1'b1, 1'b1, 1'b1, 4'hF, 11'h0, 32'h0)));
      check("rst_mid_ready", 64'(bus.req_ready), 64'd0);
      check("rst_mid_resp", 64'(bus.resp_valid), 64'd0);
      cmd_q.delete();
      m_open = 1'b0;
      @(negedge dram_clk);
      dram_rstn = 1'b1;
      return;
    end

    if (qlat >= 0) begin
      wait_cyc(tacc + qlat);
      DRAM_valid = 1'b1; DRAM_Q = q;
      @(negedge dram_clk);
      DRAM_valid = 1'b0; DRAM_Q = $urandom;
    end
    while (resp_q.size() != 0 && cyc < c0 + 100) @(negedge dram_clk);
    check("resp_arrived", 64'(resp_q.size()), 64'd0);
    check("cmds_drained", 64'(cmd_q.size()), 64'd0);
  endtask

  initial begin
    dram_rstn = 1'b0; DRAM_valid = 1'b0; DRAM_Q = '0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wstrb = '0; bus.req_wdata = '0;
    repeat (3) @(negedge dram_clk);
    check("rst_pins", 64'({DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn, DRAM_A, DRAM_D}),
          64'(pv(1'b1, 1'b1, 1'b1, 4'hF, 11'h0, 32'h0)));
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    check("rst_resp", 64'({bus.resp_valid, bus.resp_err, bus.resp_rdata}), 64'd0);
    dram_rstn = 1'b1;
    @(negedge dram_clk);
    check("ready_after_rst", 64'(bus.req_ready), 64'd1);

    // Empty row read, then row-1 write, then row-3 read (miss when rows stay open)
    do_req(1'b0, 21'h00405, 4'h0, 32'h0,        2, 32'hDEADBEEF, 1'b0);
    do_req(1'b1, 21'h00406, 4'b0101, 32'h11223344, 2, 32'hBAD0BAD0, 1'b0);
    do_req(1'b0, 21'h00C00, 4'h0, 32'h0,        1, 32'hCAFEF00D, 1'b0);
    // Timeout, then a byte-less write; stray DRAM_valid while idle must be ignored
    do_req(1'b0, 21'h00C10, 4'h0, 32'h0,       -1, 32'h0,        1'b0);
    @(negedge dram_clk);
    DRAM_valid = 1'b1; DRAM_Q = 32'h55AA55AA;
    @(negedge dram_clk);
    DRAM_valid = 1'b0;
    do_req(1'b1, 21'h00C11, 4'h0, 32'hA5A5A5A5, -1, 32'h0,        1'b0);
    do_req(1'b1, 21'h00C12, 4'hF, 32'h0BADF00D, 3, 32'h0,        1'b0);
    // Reset during ACT_WAIT; the same row must be re-activated afterwards
    do_req(1'b0, 21'h01000, 4'h0, 32'h0,        2, 32'h12345678, 1'b1);
    do_req(1'b0, 21'h01000, 4'h0, 32'h0,        TCL + 3, 32'h87654321, 1'b0);
    // Two reads to row 2
    do_req(1'b0, 21'h00800, 4'h0, 32'h0,        1, 32'h00000002, 1'b0);
    do_req(1'b0, 21'h00801, 4'h0, 32'h0,        4, 32'hFFFF0001, 1'b0);

    repeat (4) @(negedge dram_clk);
    check("final_cmd_q", 64'(cmd_q.size()), 64'd0);
    check("final_resp_q", 64'(resp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
